uart_char_receiver: RTL and testbench

Serial-to-character front end for the seven-segment display path. Receives 8N1 UART frames on the board's RX pin and holds the last good byte as an 8-bit character code, which is wired straight into the character-select input of the right-hand display's character decoder. Also gives a one-cycle strobe per good byte and a strobe per framing error, for downstream counters or LED indicators.

---
 rtl/uart_char_receiver_pkg.sv | 22 ++
 rtl/sync_2ff.sv | 35 +++
 rtl/uart_char_receiver.sv | 182 ++++++++++++++++++
 tb/tb_uart_char_receiver.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/uart_char_receiver_pkg.sv
// rtl/uart_char_receiver_pkg.sv - shared types and defaults for the UART character receiver
//
// Purpose : receiver FSM state encodings and board-level default parameters.
// Ports   : none (package).

package uart_char_receiver_pkg;

    // 25 MHz system clock / 115200 baud
    localparam int         DEFAULT_CLKS_PER_BIT = 217;

    // ASCII space, so the display decoder shows a blank digit
    localparam logic [7:0] DEFAULT_RESET_CHAR   = 8'h20;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BREAK = 3'd4
    } uart_state_t;

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop synchronizer with parameterized reset value
//
// Purpose : brings an asynchronous level into the i_Clk domain. Also reused
//           for switch inputs ahead of the debouncer.
// Ports   : i_Clk   - destination clock
//           i_Rst_L - synchronous active-low reset, loads RESET_VAL into both flops
//           i_D     - asynchronous input
//           o_Q     - synchronized output (two flops deep)

module sync_2ff #(
    parameter int               WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '1
) (
    input  logic             i_Clk,
    input  logic             i_Rst_L,
    input  logic [WIDTH-1:0] i_D,
    output logic [WIDTH-1:0] o_Q
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    always_ff @(posedge i_Clk) begin
        if (!i_Rst_L) begin
            r_meta <= RESET_VAL;
            r_sync <= RESET_VAL;
        end else begin
            r_meta <= i_D;
            r_sync <= r_meta;
        end
    end

    assign o_Q = r_sync;

endmodule

// File: rtl/uart_char_receiver.sv
// rtl/uart_char_receiver.sv - 8N1 UART receiver holding the last good byte for the display decoder
//
// Purpose : receives 8N1 frames on i_UART_RX and holds the last correctly
//           framed byte as a character code for the seven-segment decoder.
// Ports   : i_Clk       - system clock
//           i_Rst_L     - synchronous active-low reset
//           i_UART_RX   - asynchronous serial line, idles high
//           o_Character - last good byte, RESET_CHAR after reset
//           o_Valid     - one-cycle pulse when o_Character updates
//           o_Error     - one-cycle pulse when a stop bit is sampled low
//           o_Busy      - high whenever the FSM is not in IDLE

module uart_char_receiver
    import uart_char_receiver_pkg::*;
#(
    parameter int         CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter logic [7:0] RESET_CHAR   = DEFAULT_RESET_CHAR
) (
    input  logic       i_Clk,
    input  logic       i_Rst_L,
    input  logic       i_UART_RX,
    output logic [7:0] o_Character,
    output logic       o_Valid,
    output logic       o_Error,
    output logic       o_Busy
);

    localparam int CW = $clog2(CLKS_PER_BIT);

    // The counter is cleared on the edge that enters a state, so the edge on
    // which it holds N-1 is the N-th edge spent in that state.
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'((CLKS_PER_BIT - 1) / 2 - 1);

    uart_state_t   r_state;
    uart_state_t   w_state_next;
    logic [CW-1:0] r_count;
    logic [2:0]    r_index;
    logic [7:0]    r_shift;
    logic [7:0]    r_char;
    logic          r_valid;
    logic          r_error;

    logic          w_rx_s;
    logic          w_cnt_clr;
    logic          w_cnt_inc;
    logic          w_idx_clr;
    logic          w_take_bit;
    logic          w_load;
    logic          w_frame_err;

    // Reset value 1 so a reset never looks like a start edge.
    sync_2ff #(
        .WIDTH     (1),
        .RESET_VAL (1'b1)
    ) u_rx_sync (
        .i_Clk   (i_Clk),
        .i_Rst_L (i_Rst_L),
        .i_D     (i_UART_RX),
        .o_Q     (w_rx_s)
    );

    always_ff @(posedge i_Clk) begin
        if (!i_Rst_L) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_cnt_clr    = 1'b0;
        w_cnt_inc    = 1'b0;
        w_idx_clr    = 1'b0;
        w_take_bit   = 1'b0;
        w_load       = 1'b0;
        w_frame_err  = 1'b0;

        case (r_state)
            IDLE: begin
                if (!w_rx_s) begin
                    w_state_next = START;
                    w_cnt_clr    = 1'b1;
                end
            end

            START: begin
                if (r_count == HALF_LAST) begin
                    if (w_rx_s) begin
                        // Line went back high before mid start bit: glitch.
                        w_state_next = IDLE;
                    end else begin
                        w_state_next = DATA;
                        w_cnt_clr    = 1'b1;
                        w_idx_clr    = 1'b1;
                    end
                end else begin
                    w_cnt_inc = 1'b1;
                end
            end

            DATA: begin
                if (r_count == BIT_LAST) begin
                    w_take_bit = 1'b1;
                    w_cnt_clr  = 1'b1;
                    if (r_index == 3'd7) begin
                        w_state_next = STOP;
                    end
                end else begin
                    w_cnt_inc = 1'b1;
                end
            end

            STOP: begin
                if (r_count == BIT_LAST) begin
                    w_cnt_clr = 1'b1;
                    if (w_rx_s) begin
                        w_load       = 1'b1;
                        w_state_next = IDLE;
                    end else begin
                        w_frame_err  = 1'b1;
                        w_state_next = BREAK;
                    end
                end else begin
                    w_cnt_inc = 1'b1;
                end
            end

            BREAK: begin
                // Hold off until the line idles so a long break gives one error.
                if (w_rx_s) begin
                    w_state_next = IDLE;
                end
            end

            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_Clk) begin
        if (!i_Rst_L) begin
            r_count <= '0;
            r_index <= 3'd0;
            r_shift <= 8'h00;
            r_char  <= RESET_CHAR;
            r_valid <= 1'b0;
            r_error <= 1'b0;
        end else begin
            if (w_cnt_clr) begin
                r_count <= '0;
            end else if (w_cnt_inc) begin
                r_count <= r_count + CW'(1);
            end

            if (w_idx_clr) begin
                r_index <= 3'd0;
            end else if (w_take_bit) begin
                r_index <= r_index + 3'd1;
            end

            if (w_take_bit) begin
                r_shift[r_index] <= w_rx_s;
            end

            if (w_load) begin
                r_char <= r_shift;
            end

            r_valid <= w_load;
            r_error <= w_frame_err;
        end
    end

    assign o_Character = r_char;
    assign o_Valid     = r_valid;
    assign o_Error     = r_error;
    assign o_Busy      = (r_state != IDLE);

endmodule

// File: tb/tb_uart_char_receiver.sv
// tb/tb_uart_char_receiver.sv - scoreboard testbench for uart_char_receiver

module tb_uart_char_receiver;

    localparam int C        = 217;
    localparam int HALF     = (C - 1) / 2;
    localparam int STOP_OFS = 2 + HALF + 9 * C;

    typedef struct {
        bit         is_err;
        logic [7:0] ch;
        int         cyc;
    } exp_t;

    logic       clk;
    logic       rst_l;
    logic       rx;
    logic [7:0] o_char;
    logic       o_valid;
    logic       o_error;
    logic       o_busy;

    int         cyc;
    int         checks;
    int         failures;
    bit         mon_en;
    logic [7:0] model_char;
    exp_t       exp_q[$];
    int         valid_cyc[$];

    uart_char_receiver #(
        .CLKS_PER_BIT (C),
        .RESET_CHAR   (8'h20)
    ) dut (
        .i_Clk       (clk),
        .i_Rst_L     (rst_l),
        .i_UART_RX   (rx),
        .o_Character (o_char),
        .o_Valid     (o_valid),
        .o_Error     (o_error),
        .o_Busy      (o_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0d (0x%0h) required=%0d (0x%0h)", name, act, act, req, req);
        end
    endtask

    // Monitor: pops one expectation for every strobe the DUT presents.
    always @(negedge clk) begin
        if (mon_en) begin
            if (o_valid && o_error) begin
                chk("valid_error_overlap", 1, 0);
            end
            if (o_valid || o_error) begin
                if (o_valid) valid_cyc.push_back(cyc);
                if (exp_q.size() == 0) begin
                    chk("unexpected_strobe", int'(o_error), -1);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("strobe_kind_err", int'(o_error), int'(e.is_err));
                    chk("strobe_char", int'(o_char), int'(e.ch));
                    chk("strobe_cycle", cyc, e.cyc);
                end
            end
        end
    end

    task automatic drive_bits(input logic v, input int n);
        rx = v;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_val, input int stop_len);
        exp_t e;
        e.is_err = !stop_val;
        e.ch     = stop_val ? b : model_char;
        e.cyc    = cyc + 1 + STOP_OFS;
        exp_q.push_back(e);
        if (stop_val) model_char = b;
        drive_bits(1'b0, C);
        for (int k = 0; k < 8; k++) drive_bits(b[k], C);
        drive_bits(stop_val, stop_len);
    endtask

    task automatic pulse_reset();
        rst_l = 1'b0;
        @(posedge clk);
        #1;
        rst_l = 1'b1;
        model_char = 8'h20;
    endtask

    initial begin
        int t0;
        int n;
        checks     = 0;
        failures   = 0;
        mon_en     = 1'b0;
        model_char = 8'h20;
        rst_l      = 1'b0;
        rx         = 1'b1;

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        chk("reset_char", int'(o_char), 8'h20);
        chk("reset_valid", int'(o_valid), 0);
        chk("reset_error", int'(o_error), 0);
        chk("reset_busy", int'(o_busy), 0);
        rst_l = 1'b1;
        mon_en = 1'b1;
        drive_bits(1'b1, 10);

        // Single byte 'A' with busy timing around start and stop
        t0 = cyc + 1;
        fork
            send_frame(8'h41, 1'b1, C);
            begin
                while (cyc != t0 + 1) @(negedge clk);
                chk("busy_before_start", int'(o_busy), 0);
                @(negedge clk);
                chk("busy_after_start", int'(o_busy), 1);
                while (cyc != t0 + STOP_OFS - 1) @(negedge clk);
                chk("busy_before_stop", int'(o_busy), 1);
                @(negedge clk);
                chk("busy_after_stop", int'(o_busy), 0);
            end
        join
        drive_bits(1'b1, 20);
        chk("char_after_A", int'(o_char), 8'h41);

        // Glitch rejection
        drive_bits(1'b0, 50);
        drive_bits(1'b1, 400);
        chk("glitch_busy", int'(o_busy), 0);
        chk("glitch_char", int'(o_char), 8'h41);

        // Framing error: stop low, line held low 5 more bit times
        send_frame(8'h55, 1'b0, 6 * C);
        chk("break_busy_held", int'(o_busy), 1);
        drive_bits(1'b1, 4);
        chk("break_busy_released", int'(o_busy), 0);
        chk("break_char", int'(o_char), 8'h41);
        drive_bits(1'b1, 50);

        // Back-to-back 'H','I', then 'J' after a minimum-length stop
        n = valid_cyc.size();
        send_frame(8'h48, 1'b1, C);
        send_frame(8'h49, 1'b1, HALF + 3);
        send_frame(8'h4A, 1'b1, C);
        drive_bits(1'b1, 20);
        if (valid_cyc.size() >= n + 2) begin
            chk("b2b_spacing", valid_cyc[n+1] - valid_cyc[n], 10 * C);
        end else begin
            chk("b2b_valid_count", valid_cyc.size() - n, 3);
        end
        chk("char_after_J", int'(o_char), 8'h4A);

        // Reset mid-frame: 0x33 cut after data bit 3, then 0x7A
        drive_bits(1'b0, C);
        drive_bits(1'b1, C);
        drive_bits(1'b1, C);
        drive_bits(1'b0, C);
        drive_bits(1'b0, C);
        drive_bits(1'b1, 20);
        pulse_reset();
        chk("midreset_char", int'(o_char), 8'h20);
        chk("midreset_busy", int'(o_busy), 0);
        chk("midreset_valid", int'(o_valid), 0);
        drive_bits(1'b1, 3000);
        chk("midreset_no_pending", exp_q.size(), 0);
        send_frame(8'h7A, 1'b1, C);
        drive_bits(1'b1, 20);
        chk("char_after_z", int'(o_char), 8'h7A);

        // Drain any outstanding expectations with a bounded wait
        for (int i = 0; i < 5000 && exp_q.size() != 0; i++) @(negedge clk);
        chk("scoreboard_empty", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
